// File: rtl/mat_esc_pkg.sv
// Shared constants and state encoding for the matrix-by-scalar controller.
package mat_esc_pkg;
   localparam int N_ELEM = 25;
   localparam int ELEM_W = 8;
   localparam int MAT_W  = N_ELEM * ELEM_W;

   localparam int SAT_MAX = 127;
   localparam int SAT_MIN = -128;

   localparam logic [4:0] OVF_IDX_NONE = 5'd31;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;
endpackage

// File: rtl/sat_mul8_lane.sv
// Combinational signed 8x8 multiply saturated to int8, with overflow flag.
module sat_mul8_lane (
   input  logic signed [mat_esc_pkg::ELEM_W-1:0] a_i,
   input  logic signed [mat_esc_pkg::ELEM_W-1:0] b_i,
   output logic        [mat_esc_pkg::ELEM_W-1:0] y_o,
   output logic                                  ovf_o
);
   import mat_esc_pkg::*;

   localparam logic signed [15:0] P_MAX = 16'(SAT_MAX);
   localparam logic signed [15:0] P_MIN = 16'(SAT_MIN);

   logic signed [15:0] prod;

   assign prod = a_i * b_i;

   always_comb begin
      y_o   = prod[ELEM_W-1:0];
      ovf_o = 1'b0;
      if (prod > P_MAX) begin
         y_o   = ELEM_W'(SAT_MAX);
         ovf_o = 1'b1;
      end else if (prod < P_MIN) begin
         y_o   = ELEM_W'(SAT_MIN);
         ovf_o = 1'b1;
      end
   end
endmodule

// File: rtl/mat_esc_seq_ctrl.sv
// Time-multiplexed 5x5 int8 matrix-by-scalar saturating multiply controller.
// Optional abort input is enabled by defining MAT_ESC_ABORT_EN.
module mat_esc_seq_ctrl #(
   parameter int LANES  = 5,
   parameter int N_ELEM = 25
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start_i,
`ifdef MAT_ESC_ABORT_EN
   input  logic                          abort_i,
`endif
   input  logic [mat_esc_pkg::MAT_W-1:0]  mat_a_i,
   input  logic [mat_esc_pkg::ELEM_W-1:0] esc_i,
   output logic                          busy_o,
   output logic                          done_o,
   output logic [mat_esc_pkg::MAT_W-1:0]  mat_out_o,
   output logic                          overflow_o,
   output logic [4:0]                    ovf_idx_o
);
   import mat_esc_pkg::*;

   localparam int G  = N_ELEM / LANES;
   localparam int EW = ELEM_W;

   if (!((LANES == 1) || (LANES == 5) || (LANES == 25))
       || (N_ELEM != 25)) begin : g_bad_cfg
      $error("mat_esc_seq_ctrl: LANES must be 1, 5 or 25");
   end

   state_t           state;
   state_t           state_nx;
   logic [4:0]       g;
   logic [MAT_W-1:0] cap_mat;
   logic [EW-1:0]    cap_esc;
   logic [MAT_W-1:0] mat_q;
   logic             ovf_q;
   logic [4:0]       idx_q;

   logic [4:0]       lane_idx [LANES];
   logic [EW-1:0]    lane_res [LANES];
   logic [LANES-1:0] lane_ovf;
   logic [4:0]       grp_idx;
   logic             last_grp;
   logic             abort;

`ifdef MAT_ESC_ABORT_EN
   assign abort = abort_i;
`else
   assign abort = 1'b0;
`endif

   assign last_grp = (g == 5'(G - 1));

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      assign lane_idx[l] = g * 5'(LANES) + 5'(l);

      sat_mul8_lane u_mul (
         .a_i   (cap_mat[{lane_idx[l], 3'b000} +: EW]),
         .b_i   (cap_esc),
         .y_o   (lane_res[l]),
         .ovf_o (lane_ovf[l])
      );
   end

   // Scan high to low so the lowest overflowing lane wins.
   always_comb begin
      grp_idx = OVF_IDX_NONE;
      for (int i = LANES - 1; i >= 0; i--) begin
         if (lane_ovf[i]) grp_idx = lane_idx[i];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (start_i) state_nx = RUN;
         RUN: begin
            if (abort)         state_nx = IDLE;
            else if (last_grp) state_nx = DONE;
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cap_mat <= '0;
         cap_esc <= '0;
         g       <= '0;
         mat_q   <= '0;
         ovf_q   <= 1'b0;
         idx_q   <= OVF_IDX_NONE;
      end else begin
         case (state)
            IDLE: if (start_i) begin
               cap_mat <= mat_a_i;
               cap_esc <= esc_i;
               g       <= '0;
               mat_q   <= '0;
               ovf_q   <= 1'b0;
               idx_q   <= OVF_IDX_NONE;
            end
            RUN: if (abort) begin
               mat_q <= '0;
               ovf_q <= 1'b0;
               idx_q <= OVF_IDX_NONE;
            end else begin
               for (int i = 0; i < LANES; i++) begin
                  mat_q[{lane_idx[i], 3'b000} +: EW] <= lane_res[i];
               end
               g     <= last_grp ? 5'd0 : g + 5'd1;
               ovf_q <= ovf_q | (|lane_ovf);
               if (idx_q == OVF_IDX_NONE) idx_q <= grp_idx;
            end
            default: ;
         endcase
      end
   end

   assign busy_o     = (state != IDLE);
   assign done_o     = (state == DONE);
   assign mat_out_o  = mat_q;
   assign overflow_o = ovf_q;
   assign ovf_idx_o  = idx_q;
endmodule

// File: tb/tb_mat_esc_seq_ctrl.sv
// Self-checking bench: LANES=5, 1 and 25 instances side by side.
module tb_mat_esc_seq_ctrl;
   typedef logic [199:0] mat_t;

   typedef struct {
      mat_t       a;
      logic [7:0] e;
      mat_t       x;
      logic       xo;
      logic [4:0] xi;
   } vec_t;

   typedef struct {
      mat_t       x;
      logic       xo;
      logic [4:0] xi;
      int         due;
   } exp_t;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] start = 3'b000;
   logic       abort = 1'b0;
   mat_t       mat_a = '0;
   logic [7:0] esc   = '0;

   logic [2:0] busy;
   logic [2:0] done;
   logic [2:0] ovf;
   mat_t       mo   [3];
   logic [4:0] oidx [3];

   int    g_of [3] = '{5, 25, 1};
   string nm   [3] = '{"L5", "L1", "L25"};

   mat_esc_seq_ctrl #(.LANES(5)) u5 (
      .clk(clk), .rst_n(rst_n), .start_i(start[0]),
`ifdef MAT_ESC_ABORT_EN
      .abort_i(abort),
`endif
      .mat_a_i(mat_a), .esc_i(esc), .busy_o(busy[0]), .done_o(done[0]),
      .mat_out_o(mo[0]), .overflow_o(ovf[0]), .ovf_idx_o(oidx[0])
   );

   mat_esc_seq_ctrl #(.LANES(1)) u1 (
      .clk(clk), .rst_n(rst_n), .start_i(start[1]),
`ifdef MAT_ESC_ABORT_EN
      .abort_i(abort),
`endif
      .mat_a_i(mat_a), .esc_i(esc), .busy_o(busy[1]), .done_o(done[1]),
      .mat_out_o(mo[1]), .overflow_o(ovf[1]), .ovf_idx_o(oidx[1])
   );

   mat_esc_seq_ctrl #(.LANES(25)) u25 (
      .clk(clk), .rst_n(rst_n), .start_i(start[2]),
`ifdef MAT_ESC_ABORT_EN
      .abort_i(abort),
`endif
      .mat_a_i(mat_a), .esc_i(esc), .busy_o(busy[2]), .done_o(done[2]),
      .mat_out_o(mo[2]), .overflow_o(ovf[2]), .ovf_idx_o(oidx[2])
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int   checks = 0;
   int   errors = 0;
   exp_t q0 [$];
   exp_t q1 [$];
   exp_t q2 [$];
   int   ndone [3] = '{0, 0, 0};
   int   bcnt  [3] = '{0, 0, 0};

   function automatic void chk(string n, logic [199:0] act, logic [199:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", n, act, exp);
      end
   endfunction

   task automatic push(input int i, input exp_t e);
      case (i)
         0: q0.push_back(e);
         1: q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endtask

   task automatic pop(input int i, output exp_t e, output bit got);
      got = 1'b0;
      e   = '{x: '0, xo: 1'b0, xi: 5'd0, due: 0};
      case (i)
         0: if (q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
         1: if (q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
         default: if (q2.size() > 0) begin e = q2.pop_front(); got = 1'b1; end
      endcase
   endtask

   function automatic int pending();
      return q0.size() + q1.size() + q2.size();
   endfunction

   exp_t me;
   bit   mgot;

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (busy[i] === 1'b1) bcnt[i]++;
         else bcnt[i] = 0;
         if (done[i] === 1'b1) begin
            ndone[i]++;
            pop(i, me, mgot);
            if (!mgot) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done_%s act=1 exp=0", nm[i]);
            end else begin
               chk({"mat_", nm[i]}, mo[i], me.x);
               chk({"ovf_", nm[i]}, 200'(ovf[i]), 200'(me.xo));
               chk({"idx_", nm[i]}, 200'(oidx[i]), 200'(me.xi));
               chk({"lat_", nm[i]}, 200'(cyc), 200'(me.due));
               chk({"busy_", nm[i]}, 200'(bcnt[i]), 200'(g_of[i] + 1));
            end
         end
      end
   end

   function automatic mat_t uni(input logic [7:0] v);
      mat_t m;
      for (int k = 0; k < 25; k++) m[8*k +: 8] = v;
      return m;
   endfunction

   function automatic mat_t setel(input mat_t m, input int k, input logic [7:0] v);
      mat_t r;
      r = m;
      r[8*k +: 8] = v;
      return r;
   endfunction

   function automatic vec_t model(input mat_t a, input logic [7:0] e);
      vec_t v;
      int   p;
      v.a  = a;
      v.e  = e;
      v.x  = '0;
      v.xo = 1'b0;
      v.xi = 5'd31;
      for (int k = 0; k < 25; k++) begin
         p = int'($signed(a[8*k +: 8])) * int'($signed(e));
         if (p > 127 || p < -128) begin
            if (!v.xo) v.xi = 5'(k);
            v.xo = 1'b1;
            p = (p > 127) ? 127 : -128;
         end
         v.x[8*k +: 8] = p[7:0];
      end
      return v;
   endfunction

   task automatic launch(input logic [2:0] m, input vec_t v);
      exp_t e;
      @(negedge clk);
      mat_a = v.a;
      esc   = v.e;
      start = m;
      for (int i = 0; i < 3; i++) begin
         if (m[i]) begin
            e.x   = v.x;
            e.xo  = v.xo;
            e.xi  = v.xi;
            e.due = cyc + 1 + g_of[i];
            push(i, e);
         end
      end
      @(negedge clk);
      start = 3'b000;
   endtask

   task automatic wait_idle();
      for (int k = 0; k < 80; k++) begin
         @(negedge clk);
         if (busy === 3'b000 && pending() == 0) return;
      end
      checks++;
      errors++;
      $display("FAIL timeout busy=%b pending=%0d", busy, pending());
   endtask

   task automatic flush();
      q0.delete();
      q1.delete();
      q2.delete();
   endtask

   task automatic chk_clear(input string n);
      chk({n, "_busy"}, 200'(busy[0]), 200'(0));
      chk({n, "_mat"}, mo[0], '0);
      chk({n, "_ovf"}, 200'(ovf[0]), 200'(0));
      chk({n, "_idx"}, 200'(oidx[0]), 200'(31));
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog act=running exp=finished");
      $fatal(1);
   end

   vec_t tbl [8];
   vec_t rv;
   mat_t ra;
   int   base;
   int   c0;

   initial begin
      tbl[0] = '{uni(8'd3), 8'd4, uni(8'd12), 1'b0, 5'd31};
      tbl[1] = '{setel(setel(uni(8'd1), 7, 8'd64), 12, 8'h9C), 8'd2,
                 setel(setel(uni(8'd2), 7, 8'h7F), 12, 8'h80), 1'b1, 5'd7};
      tbl[2] = '{setel(uni(8'd0), 0, 8'h80), 8'hFF,
                 setel(uni(8'd0), 0, 8'h7F), 1'b1, 5'd0};
      tbl[3] = '{setel(uni(8'd0), 0, 8'h80), 8'd1,
                 setel(uni(8'd0), 0, 8'h80), 1'b0, 5'd31};
      tbl[4] = '{setel(setel(uni(8'd0), 11, 8'd50), 14, 8'd60), 8'd3,
                 setel(setel(uni(8'd0), 11, 8'h7F), 14, 8'h7F), 1'b1, 5'd11};
      tbl[5] = '{uni(8'hFF), 8'h80, uni(8'h7F), 1'b1, 5'd0};
      tbl[6] = '{setel(setel(uni(8'd10), 3, 8'hEC), 20, 8'd100), 8'hF9,
                 setel(setel(uni(8'hBA), 3, 8'h7F), 20, 8'h80), 1'b1, 5'd3};
      tbl[7] = '{uni(8'h7F), 8'd1, uni(8'h7F), 1'b0, 5'd31};

      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk({"rst_busy_", nm[i]}, 200'(busy[i]), 200'(0));
         chk({"rst_done_", nm[i]}, 200'(done[i]), 200'(0));
         chk({"rst_mat_", nm[i]}, mo[i], '0);
         chk({"rst_ovf_", nm[i]}, 200'(ovf[i]), 200'(0));
         chk({"rst_idx_", nm[i]}, 200'(oidx[i]), 200'(31));
      end
      rst_n = 1'b1;

      for (int t = 0; t < 8; t++) begin
         launch(3'b111, tbl[t]);
         wait_idle();
         repeat (2) @(negedge clk);
         chk($sformatf("hold_mat_%0d", t), mo[0], tbl[t].x);
         chk($sformatf("hold_ovf_%0d", t), 200'(ovf[0]), 200'(tbl[t].xo));
         chk($sformatf("hold_idx_%0d", t), 200'(oidx[0]), 200'(tbl[t].xi));
      end

      for (int r = 0; r < 4; r++) begin
         for (int k = 0; k < 25; k++) ra[8*k +: 8] = 8'($urandom_range(0, 255));
         rv = model(ra, 8'($urandom_range(0, 255)));
         launch(3'b111, rv);
         wait_idle();
      end

      base = ndone[0];
      launch(3'b001, tbl[0]);
      @(negedge clk);
      mat_a    = tbl[1].a;
      esc      = tbl[1].e;
      start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      wait_idle();
      chk("ignored_start_ndone", 200'(ndone[0] - base), 200'(1));

      base = ndone[0];
      @(negedge clk);
      c0 = cyc;
      mat_a    = tbl[4].a;
      esc      = tbl[4].e;
      start[0] = 1'b1;
      push(0, '{x: tbl[4].x, xo: tbl[4].xo, xi: tbl[4].xi, due: c0 + 6});
      push(0, '{x: tbl[4].x, xo: tbl[4].xo, xi: tbl[4].xi, due: c0 + 13});
      for (int k = 0; k < 20 && cyc < c0 + 8; k++) @(negedge clk);
      start[0] = 1'b0;
      wait_idle();
      chk("level_start_ndone", 200'(ndone[0] - base), 200'(2));

      base = ndone[0];
      launch(3'b001, tbl[1]);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk_clear("midrst");
      chk("midrst_done", 200'(done[0]), 200'(0));
      flush();
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      chk("midrst_ndone", 200'(ndone[0] - base), 200'(0));

`ifdef MAT_ESC_ABORT_EN
      base = ndone[0];
      launch(3'b001, tbl[1]);
      @(negedge clk);
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk_clear("abort");
      flush();
      repeat (10) @(negedge clk);
      chk("abort_ndone", 200'(ndone[0] - base), 200'(0));

      base  = ndone[0];
      abort = 1'b1;
      launch(3'b001, tbl[0]);
      abort = 1'b0;
      wait_idle();
      chk("start_wins_ndone", 200'(ndone[0] - base), 200'(1));
`endif

      launch(3'b111, tbl[1]);
      wait_idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
